// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : ID-stage hazard and pipeline-control unit.
//               Detects load-use and branch-operand hazards against the EX and
//               MEM stages. It stalls PC/IF_ID and inserts ID_EX bubbles while
//               a hazard is present. It flushes IF_ID on a taken branch or a
//               jump. A two-state FSM sequences interrupt entry: the PC takes
//               the exception vector and ID captures EPC and writes k0. A
//               saturating counter records the number of stall cycles.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               ID_Rs/Rt, ID_UseRs/Rt    - source operands of the ID instruction
//               ID_Branch/BranchTaken    - ID-resolved conditional branch
//               ID_Jump                  - j/jal/jr/jalr in ID
//               EX_MemRead/RegWrite/
//               EX_WriteRegister         - destination info of the EX instruction
//               MEM_MemRead/
//               MEM_WriteRegister        - destination info of the MEM instruction
//               Irq_Req                  - one-cycle interrupt request pulse
//               PC_Write, IF_ID_Write    - pipeline front-end enables
//               IF_ID_Flush, ID_EX_Flush - bubble insertion
//               PC_Exc                   - select exception vector
//               Irq_Ack                  - one-cycle interrupt-entry pulse
//               Stall_Count              - saturating stall-cycle counter
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UseRs,
    input  logic             ID_UseRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_Jump,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [4:0]       EX_WriteRegister,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteRegister,
    input  logic             Irq_Req,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             PC_Exc,
    output logic             Irq_Ack,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        IRQ_TAKE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             irq_p_q, irq_p_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic w_ex_match;
    logic w_mem_match;
    logic w_hz;
    logic w_redirect;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    assign w_ex_match  = (EX_WriteRegister != 5'd0) &&
                         ((ID_UseRs && (EX_WriteRegister == ID_Rs)) ||
                          (ID_UseRt && (EX_WriteRegister == ID_Rt)));
    assign w_mem_match = (MEM_WriteRegister != 5'd0) &&
                         ((ID_UseRs && (MEM_WriteRegister == ID_Rs)) ||
                          (ID_UseRt && (MEM_WriteRegister == ID_Rt)));

    // Branches compare in ID, so they need results that ALU forwarding into EX
    // cannot supply: an ALU result still in EX, or load data still in MEM.
    // A load followed by a branch therefore stalls twice (EX case, then MEM case).
    assign w_hz = (EX_MemRead && w_ex_match) ||
                  (ID_Branch && EX_RegWrite && w_ex_match) ||
                  (ID_Branch && MEM_MemRead && w_mem_match);

    assign w_redirect = ID_Jump || (ID_Branch && ID_BranchTaken);

    assign Stall_Count = cnt_q;

    always_comb begin
        state_d     = state_q;
        // A new request re-arms the flag even in the cycle that consumes it.
        irq_p_d     = Irq_Req || (irq_p_q && (state_q != IRQ_TAKE));
        cnt_d       = cnt_q;
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        PC_Exc      = 1'b0;
        Irq_Ack     = 1'b0;

        if (rst) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            state_d     = RUN;
            irq_p_d     = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IRQ_TAKE: begin
                    PC_Exc      = 1'b1;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    Irq_Ack     = 1'b1;
                    state_d     = RUN;
                end
                default: begin
                    if (w_hz) begin
                        // The redirect of a stalled branch waits until the hazard clears.
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                        if (cnt_q != c_CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (w_redirect) begin
                        IF_ID_Flush = 1'b1;
                    end
                    // Entry never cuts into a stalled or redirecting instruction,
                    // so the captured EPC always names a clean restart point.
                    if ((irq_p_q || Irq_Req) && !w_hz && !ID_Branch && !ID_Jump) begin
                        state_d = IRQ_TAKE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            irq_p_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_p_q <= irq_p_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed per-cycle
//               vectors push hand-computed expectations into a scoreboard
//               queue. A monitor on the falling edge pops them and compares
//               them with the DUT outputs. A second instance with CNT_W=2
//               shares the stimulus and is used to observe counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_Rs, ID_Rt, EX_WriteRegister, MEM_WriteRegister;
    logic       ID_UseRs, ID_UseRt, ID_Branch, ID_BranchTaken, ID_Jump;
    logic       EX_MemRead, EX_RegWrite, MEM_MemRead, Irq_Req;

    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Exc, Irq_Ack;
    logic [15:0] Stall_Count;
    logic        PC_Write2, IF_ID_Write2, IF_ID_Flush2, ID_EX_Flush2, PC_Exc2, Irq_Ack2;
    logic [1:0]  Stall_Count2;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_WriteRegister(EX_WriteRegister),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteRegister(MEM_WriteRegister),
        .Irq_Req(Irq_Req),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .PC_Exc(PC_Exc), .Irq_Ack(Irq_Ack),
        .Stall_Count(Stall_Count)
    );

    hazard_ctrl #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
        .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_WriteRegister(EX_WriteRegister),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteRegister(MEM_WriteRegister),
        .Irq_Req(Irq_Req),
        .PC_Write(PC_Write2), .IF_ID_Write(IF_ID_Write2), .IF_ID_Flush(IF_ID_Flush2),
        .ID_EX_Flush(ID_EX_Flush2), .PC_Exc(PC_Exc2), .Irq_Ack(Irq_Ack2),
        .Stall_Count(Stall_Count2)
    );

    // ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Exc, Irq_Ack}
    typedef struct {
        int          id;
        logic [5:0]  ctl;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        bit          chk2;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    localparam logic [5:0] c_RST  = 6'b001100;
    localparam logic [5:0] c_NORM = 6'b110000;
    localparam logic [5:0] c_STL  = 6'b000100;
    localparam logic [5:0] c_RDR  = 6'b111000;
    localparam logic [5:0] c_IRQ  = 6'b111111;

    task automatic idle();
        rst = 1'b0;
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0;
        ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
        EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0;
        MEM_MemRead = 1'b0; MEM_WriteRegister = 5'd0; Irq_Req = 1'b0;
    endtask

    // Push the expectation for the current cycle, then advance to just after the next edge.
    task automatic expect_cyc(input logic [5:0] ctl, input logic [15:0] cnt,
                              input bit chk2, input logic [1:0] cnt2);
        exp_t e;
        e.id = vec_id; e.ctl = ctl; e.cnt = cnt; e.cnt2 = cnt2; e.chk2 = chk2;
        exp_q.push_back(e);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_8();
        idle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd8;
        ID_Rs = 5'd8; ID_UseRs = 1'b1;
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act, act2;
            bit ok;
            e    = exp_q.pop_front();
            act  = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PC_Exc, Irq_Ack};
            act2 = {PC_Write2, IF_ID_Write2, IF_ID_Flush2, ID_EX_Flush2, PC_Exc2, Irq_Ack2};
            ok   = (act === e.ctl) && (act2 === e.ctl) && (Stall_Count === e.cnt);
            if (e.chk2 && (Stall_Count2 !== e.cnt2)) ok = 1'b0;
            n_checks++;
            if (ok) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: ctl=%b ctl2=%b cnt=%0d cnt2=%0d, required ctl=%b cnt=%0d cnt2=%0d(chk=%0d)",
                         e.id, act, act2, Stall_Count, Stall_Count2, e.ctl, e.cnt, e.cnt2, e.chk2);
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;            expect_cyc(c_RST, 16'd0, 1'b1, 2'd0);   // 0: reset state

        load_use_8();          expect_cyc(c_STL, 16'd0, 1'b0, 2'd0);   // 1: load-use stall
        idle();                expect_cyc(c_NORM, 16'd1, 1'b0, 2'd0);  // 2: single stall only

        // Load $9 then taken beq $9,$0: two stalls, then redirect.
        idle(); EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd9;
        ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Rs = 5'd9; ID_UseRs = 1'b1; ID_UseRt = 1'b1;
                               expect_cyc(c_STL, 16'd1, 1'b0, 2'd0);   // 3
        idle(); MEM_MemRead = 1'b1; MEM_WriteRegister = 5'd9;
        ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Rs = 5'd9; ID_UseRs = 1'b1; ID_UseRt = 1'b1;
                               expect_cyc(c_STL, 16'd2, 1'b0, 2'd0);   // 4
        idle(); ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Rs = 5'd9; ID_UseRs = 1'b1; ID_UseRt = 1'b1;
                               expect_cyc(c_RDR, 16'd3, 1'b0, 2'd0);   // 5

        // ALU result in EX feeding a not-taken branch via rt: one stall.
        idle(); EX_RegWrite = 1'b1; EX_WriteRegister = 5'd5;
        ID_Branch = 1'b1; ID_Rt = 5'd5; ID_UseRt = 1'b1;
                               expect_cyc(c_STL, 16'd3, 1'b0, 2'd0);   // 6
        idle(); ID_Branch = 1'b1; ID_Rt = 5'd5; ID_UseRt = 1'b1;
                               expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 7

        // Register 0 never hazards.
        idle(); EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd0;
        MEM_MemRead = 1'b1; ID_Branch = 1'b1; ID_Rs = 5'd0; ID_UseRs = 1'b1;
                               expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 8
        // Matching register that the ID instruction does not read.
        idle(); EX_MemRead = 1'b1; EX_WriteRegister = 5'd7; ID_Rs = 5'd7;
                               expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 9

        // Interrupt arriving with a jump: no entry, flush; entry follows.
        idle(); Irq_Req = 1'b1; ID_Jump = 1'b1;
                               expect_cyc(c_RDR, 16'd4, 1'b0, 2'd0);   // 10
        idle();                expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 11
        idle();                expect_cyc(c_IRQ, 16'd4, 1'b0, 2'd0);   // 12
        idle();                expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 13
        idle();                expect_cyc(c_NORM, 16'd4, 1'b0, 2'd0);  // 14

        // Interrupt with hazard; re-arm during IRQ_TAKE while a hazard is presented.
        load_use_8(); Irq_Req = 1'b1;
                               expect_cyc(c_STL, 16'd4, 1'b0, 2'd0);   // 15
        idle();                expect_cyc(c_NORM, 16'd5, 1'b0, 2'd0);  // 16
        load_use_8(); Irq_Req = 1'b1;
                               expect_cyc(c_IRQ, 16'd5, 1'b0, 2'd0);   // 17
        idle();                expect_cyc(c_NORM, 16'd5, 1'b0, 2'd0);  // 18
        idle();                expect_cyc(c_IRQ, 16'd5, 1'b0, 2'd0);   // 19
        idle();                expect_cyc(c_NORM, 16'd5, 1'b0, 2'd0);  // 20

        // Reset in the IRQ_TAKE cycle abandons the entry.
        idle(); Irq_Req = 1'b1;
                               expect_cyc(c_NORM, 16'd5, 1'b0, 2'd0);  // 21
        idle(); rst = 1'b1;    expect_cyc(c_RST, 16'd5, 1'b0, 2'd0);   // 22
        idle();                expect_cyc(c_NORM, 16'd0, 1'b1, 2'd0);  // 23
        idle();                expect_cyc(c_NORM, 16'd0, 1'b1, 2'd0);  // 24

        // Five hazard cycles: narrow counter saturates at 3.
        load_use_8();          expect_cyc(c_STL, 16'd0, 1'b1, 2'd0);   // 25
        load_use_8();          expect_cyc(c_STL, 16'd1, 1'b1, 2'd1);   // 26
        load_use_8();          expect_cyc(c_STL, 16'd2, 1'b1, 2'd2);   // 27
        load_use_8();          expect_cyc(c_STL, 16'd3, 1'b1, 2'd3);   // 28
        load_use_8();          expect_cyc(c_STL, 16'd4, 1'b1, 2'd3);   // 29
        idle();                expect_cyc(c_NORM, 16'd5, 1'b1, 2'd3);  // 30

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
